regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor of the datapath register file: configurable width and depth, two write ports, optional write-to-read bypass, per-register pending (scoreboard) bits.
- Sits in the decode/writeback stage of the pipelined core. Port 3 serves ALU writeback; port 4 serves load/base-update writeback.
- The top index is the PC alias: reads return the external `r15` input; writes to it are discarded.
- Scoreboard lets decode stall on registers with in-flight producers.

Parameters:
- WIDTH, 32, data width of every register and data port.
- NREGS, 16, number of architectural indices including the PC alias; range 2..2^AW.
- AW, 4, address width of all address ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports and pending masked; 0 = reads see stored value only.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all registers and pending bits.
- ra1  in  AW  read address, port 1.
- ra2  in  AW  read address, port 2.
- rd1  out  WIDTH  read data, port 1 (combinational).
- rd2  out  WIDTH  read data, port 2 (combinational).
- r15  in  WIDTH  PC+8 value returned when reading index NREGS-1.
- we3  in  1  write enable, port 3.
- wa3  in  AW  write address, port 3.
- wd3  in  WIDTH  write data, port 3.
- we4  in  1  write enable, port 4.
- wa4  in  AW  write address, port 4.
- wd4  in  WIDTH  write data, port 4.
- iss_en  in  1  issue: mark iss_addr pending.
- iss_addr  in  AW  destination of issued instruction.
- pend1  out  1  ra1 has an outstanding producer.
- pend2  out  1  ra2 has an outstanding producer.
- hazard  out  1  pend1 OR pend2.

Behaviour:

Storage and reset:
- Storage is indices 0..NREGS-2 (PC alias holds no storage), plus pending bits 0..NREGS-2.
- reset asserted: all registers go to 0 and all pending bits go to 0 immediately, without waiting for clk. While reset is high, writes and issues are ignored.
- Outputs during/after reset: rd1/rd2 = 0 for storage indices, r15 for the PC index; pend1 = pend2 = hazard = 0.

Writes (posedge clk):
- we3 updates rf[wa3] with wd3; we4 updates rf[wa4] with wd4.
- Both enabled with wa3 == wa4: port 4 wins.
- Writes are discarded when the address is NREGS-1 (PC) or ≥ NREGS.

Reads (combinational, zero latency):
- Address NREGS-1: rd = r15.
- Address ≥ NREGS: rd = 0.
- Otherwise, with BYPASS=1: if the address matches an enabled, non-discarded write this cycle, rd is that write's data (port 4 before port 3); else rd = stored value.
- With BYPASS=0: rd = stored value; the new value is visible the cycle after the edge.

Scoreboard (posedge clk):
- Any enabled write clears pending[addr].
- iss_en sets pending[iss_addr].
- Same edge, same address, issue and write: set wins (the new producer supersedes).
- iss_addr == PC index or ≥ NREGS: ignored.
- Issuing an already-pending register leaves it set; there is no counting, so one write clears it.

Pending outputs (combinational):
- pendN = pending[raN], forced to 0 for the PC index and out-of-range addresses.
- With BYPASS=1, pendN is also forced to 0 when an enabled write to raN occurs this cycle, because the data is forwarded.
- hazard = pend1 | pend2.

Test Plan:
- Reset mid-operation: write rf[3]=0xDEADBEEF, issue r3, then pulse reset between clock edges → rd1 for ra1=3 reads 0 and pend1=0 immediately, before the next edge.
- Dual-write collision: we3=we4=1, wa3=wa4=5, wd3=0x11, wd4=0x22, edge → ra1=5 reads 0x22. Same-cycle with BYPASS=1 → rd1=0x22 before the edge.
- PC alias: r15=0x108, ra2=15, we3=1, wa3=15, wd3=0x55 → rd2=0x108 before and after the edge; no storage changes.
- Bypass vs none: ra1=7, we4=1, wa4=7, wd4=0xA5A5 → BYPASS=1 gives rd1=0xA5A5 in the same cycle. BYPASS=0 gives the old value in the same cycle and 0xA5A5 the next cycle.
- Scoreboard lifecycle, ra1=2 throughout:
  - Issue r2 → next cycle pend1=1, hazard=1.
  - Write r2 via we3 with BYPASS=1 → pend1=0 in that cycle; after the edge pending[2]=0.
  - Same edge issue and write r2 → pending[2]=1 afterwards.
- Non-default params: WIDTH=16, NREGS=12, AW=4 → write to address 13 is ignored and reads of 13 return 0. Index 11 aliases r15; index 10 stores normally.

Source files
------------

// File: rtl/regfile_sb.sv
// Two-write-port register file with a PC alias at the top index, optional
// same-cycle write forwarding, and per-register pending bits for decode stalls.
module regfile_sb #(
   parameter int WIDTH  = 32,
   parameter int NREGS  = 16,
   parameter int AW     = 4,
   parameter int BYPASS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic [WIDTH-1:0] r15,
   input  logic             we3,
   input  logic [AW-1:0]    wa3,
   input  logic [WIDTH-1:0] wd3,
   input  logic             we4,
   input  logic [AW-1:0]    wa4,
   input  logic [WIDTH-1:0] wd4,
   input  logic             iss_en,
   input  logic [AW-1:0]    iss_addr,
   output logic             pend1,
   output logic             pend2,
   output logic             hazard
);

   localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

   logic [WIDTH-1:0] r_rf [NREGS-1];
   logic [NREGS-2:0] r_pend;

   logic             w_wr3;
   logic             w_wr4;
   logic             w_iss;
   logic [AW-1:0]    w_ra   [2];
   logic [WIDTH-1:0] w_st   [2];
   logic             w_sp   [2];
   logic [WIDTH-1:0] w_rd   [2];
   logic             w_pend [2];

   // Only storage indices (below the PC alias) may be written or issued.
   assign w_wr3 = we3    && (wa3      < PC_IDX);
   assign w_wr4 = we4    && (wa4      < PC_IDX);
   assign w_iss = iss_en && (iss_addr < PC_IDX);

   assign w_ra[0] = ra1;
   assign w_ra[1] = ra2;

   // Register storage and scoreboard; port 4 wins a write collision, issue wins over a clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS - 1; i++) begin
            r_rf[i] <= '0;
         end
         r_pend <= '0;
      end else begin
         for (int i = 0; i < NREGS - 1; i++) begin
            if (w_wr4 && (wa4 == AW'(i))) begin
               r_rf[i] <= wd4;
            end else if (w_wr3 && (wa3 == AW'(i))) begin
               r_rf[i] <= wd3;
            end else begin
               r_rf[i] <= r_rf[i];
            end

            if (w_iss && (iss_addr == AW'(i))) begin
               r_pend[i] <= 1'b1;
            end else if ((w_wr3 && (wa3 == AW'(i))) || (w_wr4 && (wa4 == AW'(i)))) begin
               r_pend[i] <= 1'b0;
            end else begin
               r_pend[i] <= r_pend[i];
            end
         end
      end
   end

   // Read muxes: PC alias, then forwarded write data, then stored value (zero when out of range).
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_st[p] = '0;
         w_sp[p] = 1'b0;
         for (int i = 0; i < NREGS - 1; i++) begin
            if (w_ra[p] == AW'(i)) begin
               w_st[p] = r_rf[i];
               w_sp[p] = r_pend[i];
            end else begin
               w_st[p] = w_st[p];
               w_sp[p] = w_sp[p];
            end
         end

         if (w_ra[p] == PC_IDX) begin
            w_rd[p]   = r15;
            w_pend[p] = 1'b0;
         end else if ((BYPASS != 0) && w_wr4 && (wa4 == w_ra[p])) begin
            w_rd[p]   = wd4;
            w_pend[p] = 1'b0;
         end else if ((BYPASS != 0) && w_wr3 && (wa3 == w_ra[p])) begin
            w_rd[p]   = wd3;
            w_pend[p] = 1'b0;
         end else begin
            w_rd[p]   = w_st[p];
            w_pend[p] = w_sp[p];
         end
      end
   end

   assign rd1    = w_rd[0];
   assign rd2    = w_rd[1];
   assign pend1  = w_pend[0];
   assign pend2  = w_pend[1];
   assign hazard = w_pend[0] | w_pend[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default, no-bypass and a narrow 12-entry instance.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  ra1, ra2, wa3, wa4, iss_addr;
   logic [31:0] r15, wd3, wd4;
   logic        we3, we4, iss_en;
   logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
   logic        pend1, pend2, hazard, nb_pend1, nb_pend2, nb_hazard;

   logic [3:0]  p_ra1, p_ra2, p_wa3, p_wa4, p_iss_addr;
   logic [15:0] p_r15, p_wd3, p_wd4, p_rd1, p_rd2;
   logic        p_we3, p_we4, p_iss_en, p_pend1, p_pend2, p_hazard;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .r15(r15),
      .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
      .iss_en(iss_en), .iss_addr(iss_addr), .pend1(pend1), .pend2(pend2), .hazard(hazard)
   );

   regfile_sb #(.BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2), .r15(r15),
      .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
      .iss_en(iss_en), .iss_addr(iss_addr), .pend1(nb_pend1), .pend2(nb_pend2), .hazard(nb_hazard)
   );

   regfile_sb #(.WIDTH(16), .NREGS(12), .AW(4), .BYPASS(1)) dut_p (
      .clk(clk), .reset(reset), .ra1(p_ra1), .ra2(p_ra2), .rd1(p_rd1), .rd2(p_rd2), .r15(p_r15),
      .we3(p_we3), .wa3(p_wa3), .wd3(p_wd3), .we4(p_we4), .wa4(p_wa4), .wd4(p_wd4),
      .iss_en(p_iss_en), .iss_addr(p_iss_addr), .pend1(p_pend1), .pend2(p_pend2), .hazard(p_hazard)
   );

   typedef struct {
      logic        we3;  logic [3:0] wa3; logic [31:0] wd3;
      logic        we4;  logic [3:0] wa4; logic [31:0] wd4;
      logic        iss;  logic [3:0] ia;
      logic [3:0]  ra1;  logic [3:0] ra2; logic [31:0] r15;
      logic [31:0] e_rd1; logic [31:0] e_rd2;
      logic        e_p1; logic e_p2; logic e_hz;
      logic [31:0] e_nb_rd1; logic e_nb_p1;
   } vec_t;

   typedef struct {
      logic [31:0] rd1; logic [31:0] rd2;
      logic        p1;  logic p2; logic hz;
      logic [31:0] nb_rd1; logic nb_p1;
   } exp_t;

   vec_t tbl [18];
   exp_t sb_q [$];

   function automatic vec_t mk(
      input logic we3_i, input logic [3:0] wa3_i, input logic [31:0] wd3_i,
      input logic we4_i, input logic [3:0] wa4_i, input logic [31:0] wd4_i,
      input logic iss_i, input logic [3:0] ia_i,
      input logic [3:0] ra1_i, input logic [3:0] ra2_i, input logic [31:0] r15_i,
      input logic [31:0] e1, input logic [31:0] e2, input logic ep1, input logic ep2,
      input logic ehz, input logic [31:0] enb1, input logic enbp1);
      vec_t v;
      v.we3 = we3_i; v.wa3 = wa3_i; v.wd3 = wd3_i;
      v.we4 = we4_i; v.wa4 = wa4_i; v.wd4 = wd4_i;
      v.iss = iss_i; v.ia = ia_i; v.ra1 = ra1_i; v.ra2 = ra2_i; v.r15 = r15_i;
      v.e_rd1 = e1; v.e_rd2 = e2; v.e_p1 = ep1; v.e_p2 = ep2; v.e_hz = ehz;
      v.e_nb_rd1 = enb1; v.e_nb_p1 = enbp1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_main();
      we3 = 1'b0; wa3 = 4'd0; wd3 = 32'd0;
      we4 = 1'b0; wa4 = 4'd0; wd4 = 32'd0;
      iss_en = 1'b0; iss_addr = 4'd0;
   endtask

   task automatic idle_p();
      p_we3 = 1'b0; p_wa3 = 4'd0; p_wd3 = 16'd0;
      p_we4 = 1'b0; p_wa4 = 4'd0; p_wd4 = 16'd0;
      p_iss_en = 1'b0; p_iss_addr = 4'd0;
   endtask

   initial begin
      exp_t e;
      reset = 1'b1;
      idle_main(); idle_p();
      ra1 = 4'd0; ra2 = 4'd15; r15 = 32'h0000_0108;
      p_ra1 = 4'd0; p_ra2 = 4'd11; p_r15 = 16'h0ABC;

      //            we3   wa3    wd3            we4   wa4    wd4           iss   ia     ra1    ra2    r15            rd1            rd2            p1    p2    hz    nb_rd1         nb_p1
      tbl[0]  = mk(1'b0, 4'd0,  32'h0,         1'b0, 4'd0, 32'h0,         1'b0, 4'd0,  4'd3,  4'd15, 32'h0000_0108, 32'h0,         32'h0000_0108, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0);
      tbl[1]  = mk(1'b1, 4'd3,  32'hDEADBEEF,  1'b0, 4'd0, 32'h0,         1'b0, 4'd0,  4'd3,  4'd4,  32'h0000_0108, 32'hDEADBEEF,  32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0);
      tbl[2]  = mk(1'b1, 4'd5,  32'h11,        1'b1, 4'd5, 32'h22,        1'b0, 4'd0,  4'd5,  4'd3,  32'h0000_0108, 32'h22,        32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0);
      tbl[3]  = mk(1'b1, 4'd15, 32'h55,        1'b0, 4'd0, 32'h0,         1'b0, 4'd0,  4'd5,  4'd15, 32'h0000_0108, 32'h22,        32'h0000_0108, 1'b0, 1'b0, 1'b0, 32'h22,        1'b0);
      tbl[4]  = mk(1'b0, 4'd0,  32'h0,         1'b0, 4'd0, 32'h0,         1'b0, 4'd0,  4'd15, 4'd15, 32'h0000_0200, 32'h0000_0200, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 1'b0);
      tbl[5]  = mk(1'b0, 4'd0,  32'h0,         1'b1, 4'd7, 32'hA5A5,      1'b0, 4'd0,  4'd7,  4'd5,  32'h0000_0108, 32'hA5A5,      32'h22,        1'b0, 1'b0, 1'b0, 32'h0,         1'b0);
      tbl[6]  = mk(1'b0, 4'd0,  32'h0,         1'b0, 4'd0, 32'h0,         1'b0, 4'd0,  4'd7,  4'd3,  32'h0000_0108, 32'hA5A5,      32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 32'hA5A5,      1'b0);
      tbl[7]  = mk(1'b0, 4'd0,  32'h0,         1'b0, 4'd0, 32'h0,         1'b1, 4'd2,  4'd2,  4'd2,  32'h0000_0108, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0);
      tbl[8]  = mk(1'b0, 4'd0,  32'h0,         1'b0, 4'd0, 32'h0,         1'b0, 4'd0,  4'd2,  4'd2,  32'h0000_0108, 32'h0,         32'h0,         1'b1, 1'b1, 1'b1, 32'h0,         1'b1);
      tbl[9]  = mk(1'b1, 4'd2,  32'h77,        1'b0, 4'd0, 32'h0,         1'b0, 4'd0,  4'd2,  4'd9,  32'h0000_0108, 32'h77,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1);
      tbl[10] = mk(1'b0, 4'd0,  32'h0,         1'b0, 4'd0, 32'h0,         1'b0, 4'd0,  4'd2,  4'd9,  32'h0000_0108, 32'h77,        32'h0,         1'b0, 1'b0, 1'b0, 32'h77,        1'b0);
      tbl[11] = mk(1'b0, 4'd0,  32'h0,         1'b1, 4'd2, 32'h99,        1'b1, 4'd2,  4'd2,  4'd9,  32'h0000_0108, 32'h99,        32'h0,         1'b0, 1'b0, 1'b0, 32'h77,        1'b0);
      tbl[12] = mk(1'b0, 4'd0,  32'h0,         1'b0, 4'd0, 32'h0,         1'b0, 4'd0,  4'd2,  4'd9,  32'h0000_0108, 32'h99,        32'h0,         1'b1, 1'b0, 1'b1, 32'h99,        1'b1);
      tbl[13] = mk(1'b0, 4'd0,  32'h0,         1'b0, 4'd0, 32'h0,         1'b1, 4'd2,  4'd0,  4'd2,  32'h0000_0108, 32'h0,         32'h99,        1'b0, 1'b1, 1'b1, 32'h0,         1'b0);
      tbl[14] = mk(1'b1, 4'd2,  32'hAB,        1'b0, 4'd0, 32'h0,         1'b0, 4'd0,  4'd2,  4'd0,  32'h0000_0108, 32'hAB,        32'h0,         1'b0, 1'b0, 1'b0, 32'h99,        1'b1);
      tbl[15] = mk(1'b0, 4'd0,  32'h0,         1'b0, 4'd0, 32'h0,         1'b0, 4'd0,  4'd2,  4'd0,  32'h0000_0108, 32'hAB,        32'h0,         1'b0, 1'b0, 1'b0, 32'hAB,        1'b0);
      tbl[16] = mk(1'b0, 4'd0,  32'h0,         1'b0, 4'd0, 32'h0,         1'b1, 4'd15, 4'd15, 4'd2,  32'h0000_0300, 32'h0000_0300, 32'hAB,        1'b0, 1'b0, 1'b0, 32'h0000_0300, 1'b0);
      tbl[17] = mk(1'b0, 4'd0,  32'h0,         1'b0, 4'd0, 32'h0,         1'b0, 4'd0,  4'd15, 4'd2,  32'h0000_0300, 32'h0000_0300, 32'hAB,        1'b0, 1'b0, 1'b0, 32'h0000_0300, 1'b0);

      // Outputs while reset is held
      #12;
      chk("reset rd1",    rd1,    32'h0);
      chk("reset rd2 pc", rd2,    32'h0000_0108);
      chk("reset hazard", {31'd0, hazard}, 32'h0);
      chk("reset p_rd2 pc", {16'd0, p_rd2}, 32'h0000_0ABC);
      reset = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         we3 = tbl[i].we3; wa3 = tbl[i].wa3; wd3 = tbl[i].wd3;
         we4 = tbl[i].we4; wa4 = tbl[i].wa4; wd4 = tbl[i].wd4;
         iss_en = tbl[i].iss; iss_addr = tbl[i].ia;
         ra1 = tbl[i].ra1; ra2 = tbl[i].ra2; r15 = tbl[i].r15;
         e.rd1 = tbl[i].e_rd1; e.rd2 = tbl[i].e_rd2;
         e.p1 = tbl[i].e_p1; e.p2 = tbl[i].e_p2; e.hz = tbl[i].e_hz;
         e.nb_rd1 = tbl[i].e_nb_rd1; e.nb_p1 = tbl[i].e_nb_p1;
         sb_q.push_back(e);
         #1;
         if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL v%0d scoreboard empty: got 0 entries expected 1", i);
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("v%0d rd1", i),    rd1, e.rd1);
            chk($sformatf("v%0d rd2", i),    rd2, e.rd2);
            chk($sformatf("v%0d pend1", i),  {31'd0, pend1},  {31'd0, e.p1});
            chk($sformatf("v%0d pend2", i),  {31'd0, pend2},  {31'd0, e.p2});
            chk($sformatf("v%0d hazard", i), {31'd0, hazard}, {31'd0, e.hz});
            chk($sformatf("v%0d nb_rd1", i), nb_rd1, e.nb_rd1);
            chk($sformatf("v%0d nb_pend1", i), {31'd0, nb_pend1}, {31'd0, e.nb_p1});
         end
      end

      // Reset between edges clears storage and pending without a clock
      @(negedge clk);
      idle_main(); iss_en = 1'b1; iss_addr = 4'd3; ra1 = 4'd3; ra2 = 4'd15; r15 = 32'h0000_0108;
      @(negedge clk);
      idle_main();
      #1;
      chk("pre-reset rd1",   rd1, 32'hDEADBEEF);
      chk("pre-reset pend1", {31'd0, pend1}, 32'h1);
      #1 reset = 1'b1;
      #1;
      chk("async reset rd1",    rd1, 32'h0);
      chk("async reset pend1",  {31'd0, pend1}, 32'h0);
      chk("async reset rd2 pc", rd2, 32'h0000_0108);
      chk("async reset nb_rd1", nb_rd1, 32'h0);
      we3 = 1'b1; wa3 = 4'd4; wd3 = 32'h0000_F00D; iss_en = 1'b1; iss_addr = 4'd4;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; idle_main(); ra1 = 4'd4;
      #1;
      chk("write in reset ignored", rd1, 32'h0);
      chk("issue in reset ignored", {31'd0, pend1}, 32'h0);

      // Narrow instance: out-of-range discard, PC alias at 11, index 10 stores
      @(negedge clk);
      p_we3 = 1'b1; p_wa3 = 4'd13; p_wd3 = 16'h1234;
      p_we4 = 1'b1; p_wa4 = 4'd10; p_wd4 = 16'hBEEF;
      p_iss_en = 1'b1; p_iss_addr = 4'd13;
      p_ra1 = 4'd13; p_ra2 = 4'd10;
      #1;
      chk("p oob rd1 same cycle", {16'd0, p_rd1}, 32'h0);
      chk("p bypass rd2 idx10",   {16'd0, p_rd2}, 32'h0000_BEEF);
      @(negedge clk);
      idle_p();
      #1;
      chk("p oob rd1 after",   {16'd0, p_rd1}, 32'h0);
      chk("p idx10 stored",    {16'd0, p_rd2}, 32'h0000_BEEF);
      chk("p oob issue ignored", {31'd0, p_hazard}, 32'h0);
      p_we3 = 1'b1; p_wa3 = 4'd11; p_wd3 = 16'h5555; p_r15 = 16'hCAFE;
      p_iss_en = 1'b1; p_iss_addr = 4'd10; p_ra1 = 4'd11;
      #1;
      chk("p pc rd1 same cycle", {16'd0, p_rd1}, 32'h0000_CAFE);
      @(negedge clk);
      idle_p();
      #1;
      chk("p pc rd1 after",  {16'd0, p_rd1}, 32'h0000_CAFE);
      chk("p pend2 idx10",   {31'd0, p_pend2}, 32'h1);
      chk("p hazard idx10",  {31'd0, p_hazard}, 32'h1);
      p_ra1 = 4'd12;
      #1;
      chk("p idx12 reads 0", {16'd0, p_rd1}, 32'h0);
      chk("p idx12 not pending", {31'd0, p_pend1}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
